// File: rtl/tensor_pkg.sv
// Shared types and constants for the tensor datapath: element geometry,
// the matrix-multiply FSM state encoding and an element-slice helper.
package tensor_pkg;

  localparam int DATA_W   = 16;
  localparam int DIM      = 3;
  localparam int IDX_W    = 4;
  localparam int TENSOR_W = DIM * DIM * DATA_W;
  localparam int VEC_W    = DIM * DATA_W;
  localparam int PROD_W   = 2 * DATA_W;
  localparam int SUM_W    = 2 * DATA_W + 2;
  localparam int RC_W     = (DIM > 1) ? $clog2(DIM) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM * DIM - 1);
  localparam logic [RC_W-1:0]  LAST_RC  = RC_W'(DIM - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } mxu_state_e;

  // LSB position of element idx inside a packed vector or tensor.
  function automatic int elem_lsb(input int idx);
    return idx * DATA_W;
  endfunction

endpackage

// File: rtl/mxu_dot.sv
// Combinational DIM-term signed dot product with optional addend.
// Result reduction: saturating when MXU_SAT_EN is defined, wrapping otherwise.
module mxu_dot
  import tensor_pkg::*;
(
  input  logic [VEC_W-1:0]  row_i,
  input  logic [VEC_W-1:0]  col_i,
  input  logic [DATA_W-1:0] addend_i,
  input  logic              add_en_i,
  output logic [DATA_W-1:0] elem_o
);

  logic [PROD_W-1:0] prod [DIM];
  logic [SUM_W-1:0]  sum;

  for (genvar k = 0; k < DIM; k++) begin : g_prod
    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    assign a_ext = {{DATA_W{row_i[k*DATA_W + DATA_W-1]}}, row_i[k*DATA_W +: DATA_W]};
    assign b_ext = {{DATA_W{col_i[k*DATA_W + DATA_W-1]}}, col_i[k*DATA_W +: DATA_W]};
    // Sign-extended operands make the low PROD_W bits the exact signed product.
    assign prod[k] = a_ext * b_ext;
  end

  always_comb begin
    sum = add_en_i ? {{(SUM_W-DATA_W){addend_i[DATA_W-1]}}, addend_i} : '0;
    for (int k = 0; k < DIM; k++) begin
      sum = sum + {{(SUM_W-PROD_W){prod[k][PROD_W-1]}}, prod[k]};
    end
  end

`ifdef MXU_SAT_EN
  localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic fits;
  // The sum is representable when every bit above the result sign agrees with it.
  assign fits   = (&sum[SUM_W-1:DATA_W-1]) | ~(|sum[SUM_W-1:DATA_W-1]);
  assign elem_o = fits ? sum[DATA_W-1:0] : (sum[SUM_W-1] ? SAT_NEG : SAT_POS);
`else
  assign elem_o = DATA_W'(sum);
`endif

endmodule

// File: rtl/mxu_seq.sv
// Sequential 3x3 signed matrix multiply C = A*B (+ addend), one element per cycle.
// MXU_SAT_EN selects saturating instead of wrapping element reduction.
module mxu_seq
  import tensor_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                accumulate,
  input  logic [TENSOR_W-1:0] a_in,
  input  logic [TENSOR_W-1:0] b_in,
  input  logic [TENSOR_W-1:0] c_in,
  output logic                busy,
  output logic                done,
  output logic [IDX_W-1:0]    elem_idx,
  output logic [TENSOR_W-1:0] mxu_out
);

  mxu_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [RC_W-1:0]     row_q, row_d;
  logic [RC_W-1:0]     col_q, col_d;
  logic                acc_q, acc_d;
  logic                done_q, done_d;
  logic [TENSOR_W-1:0] a_q, a_d;
  logic [TENSOR_W-1:0] b_q, b_d;
  logic [TENSOR_W-1:0] c_q, c_d;
  logic [TENSOR_W-1:0] res_q, res_d;
  logic [TENSOR_W-1:0] out_q, out_d;

  logic [VEC_W-1:0]    row_vec;
  logic [VEC_W-1:0]    col_vec;
  logic [DATA_W-1:0]   addend;
  logic [DATA_W-1:0]   dot_elem;

  // Route row r of A and column c of B into the single dot-product unit.
  always_comb begin
    row_vec = '0;
    col_vec = '0;
    for (int k = 0; k < DIM; k++) begin
      row_vec[elem_lsb(k) +: DATA_W] = a_q[elem_lsb(int'(row_q) * DIM + k) +: DATA_W];
      col_vec[elem_lsb(k) +: DATA_W] = b_q[elem_lsb(k * DIM + int'(col_q)) +: DATA_W];
    end
  end

  assign addend = c_q[elem_lsb(int'(idx_q)) +: DATA_W];

  mxu_dot u_dot (
    .row_i    (row_vec),
    .col_i    (col_vec),
    .addend_i (addend),
    .add_en_i (acc_q),
    .elem_o   (dot_elem)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    out_d   = out_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          c_d     = c_in;
          acc_d   = accumulate;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        res_d[elem_lsb(int'(idx_q)) +: DATA_W] = dot_elem;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          if (col_q == LAST_RC) begin
            col_d = '0;
            row_d = row_q + RC_W'(1);
          end else begin
            col_d = col_q + RC_W'(1);
          end
        end
      end
      DONE: begin
        out_d   = res_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: operand and result registers are reset too, so a post-reset read of mxu_out is zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      out_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      out_q   <= out_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign elem_idx = (state_q == COMPUTE) ? idx_q : '0;
  assign mxu_out  = out_q;

endmodule

// File: tb/tb_mxu_seq.sv
// Self-checking bench for mxu_seq: directed and random matrices against a
// plain-arithmetic matrix-multiply model, plus handshake and reset scenarios.
`timescale 1ns/1ps
module tb_mxu_seq;
  import tensor_pkg::*;

  localparam int N   = DIM * DIM;
  localparam int OBS = 24;
  localparam longint SAT_MAX = (longint'(1) <<< (DATA_W - 1)) - 1;
  localparam longint SAT_MIN = -(longint'(1) <<< (DATA_W - 1));

  typedef int mat_t [N];

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic                accumulate = 1'b0;
  logic [TENSOR_W-1:0] a_in = '0;
  logic [TENSOR_W-1:0] b_in = '0;
  logic [TENSOR_W-1:0] c_in = '0;
  logic                busy;
  logic                done;
  logic [IDX_W-1:0]    elem_idx;
  logic [TENSOR_W-1:0] mxu_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Observation trace, index j = sample taken just after edge T+j (T = accept edge).
  logic                busy_tr [OBS];
  logic                done_tr [OBS];
  logic [IDX_W-1:0]    idx_tr  [OBS];
  logic [TENSOR_W-1:0] out_tr  [OBS];

  always #5 clk = ~clk;

  mxu_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .accumulate (accumulate),
    .a_in       (a_in),
    .b_in       (b_in),
    .c_in       (c_in),
    .busy       (busy),
    .done       (done),
    .elem_idx   (elem_idx),
    .mxu_out    (mxu_out)
  );

  function automatic logic [TENSOR_W-1:0] pack(input mat_t m);
    logic [TENSOR_W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DATA_W +: DATA_W] = m[i][DATA_W-1:0];
    return v;
  endfunction

  function automatic logic [TENSOR_W-1:0] ref_mul(input mat_t a, input mat_t b,
                                                  input mat_t c, input bit acc);
    logic [TENSOR_W-1:0] res;
    longint s;
    res = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int col = 0; col < DIM; col++) begin
        s = 0;
        for (int k = 0; k < DIM; k++) s += longint'(a[r*DIM+k]) * longint'(b[k*DIM+col]);
        if (acc) s += longint'(c[r*DIM+col]);
`ifdef MXU_SAT_EN
        if (s > SAT_MAX) s = SAT_MAX;
        else if (s < SAT_MIN) s = SAT_MIN;
`endif
        res[(r*DIM+col)*DATA_W +: DATA_W] = s[DATA_W-1:0];
      end
    end
    return res;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Launch one operation and record OBS post-edge samples.
  // mode 1: re-pulse start with other operands at elem_idx 4; mode 2: change operands mid-compute.
  task automatic run_op(input mat_t a, input mat_t b, input mat_t c, input bit acc, input int mode);
    a_in = pack(a);
    b_in = pack(b);
    c_in = pack(c);
    accumulate = acc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    accumulate = ~acc;
    for (int j = 0; j < OBS; j++) begin
      busy_tr[j] = busy;
      done_tr[j] = done;
      idx_tr[j]  = elem_idx;
      out_tr[j]  = mxu_out;
      if (mode == 1 && j == 4) begin
        start = 1'b1;
        a_in  = ~a_in;
        b_in  = {$urandom, $urandom, $urandom, $urandom, $urandom};
        accumulate = 1'b1;
      end
      if (mode == 1 && j == 5) start = 1'b0;
      if (mode == 2 && j == 3) begin
        a_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
        b_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
        c_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++;
    if (elem_idx !== '0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", elem_idx); end
    n_checks++;
    if (mxu_out !== '0) begin n_fail++; $display("FAIL reset_out: got %h expected 0", mxu_out); end
    #2 reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  task automatic test_identity();
    mat_t a, b, z;
    logic [TENSOR_W-1:0] exp_out;
    for (int i = 0; i < N; i++) begin
      a[i] = (i % (DIM + 1) == 0) ? 1 : 0;
      b[i] = i + 1;
      z[i] = 0;
    end
    exp_out = ref_mul(a, b, z, 1'b0);
    run_op(a, b, z, 1'b0, 0);
    for (int j = 0; j < OBS; j++) begin
      n_checks++;
      if (busy_tr[j] !== (j <= 9)) begin
        n_fail++; $display("FAIL ident_busy[%0d]: got %b expected %b", j, busy_tr[j], (j <= 9));
      end
      n_checks++;
      if (done_tr[j] !== (j == 10)) begin
        n_fail++; $display("FAIL ident_done[%0d]: got %b expected %b", j, done_tr[j], (j == 10));
      end
      n_checks++;
      if (idx_tr[j] !== IDX_W'((j <= 8) ? j : 0)) begin
        n_fail++; $display("FAIL ident_idx[%0d]: got %0d expected %0d", j, idx_tr[j], (j <= 8) ? j : 0);
      end
    end
    n_checks++;
    if (out_tr[9] !== '0) begin n_fail++; $display("FAIL ident_out_early: got %h expected 0", out_tr[9]); end
    n_checks++;
    if (out_tr[10] !== exp_out) begin
      n_fail++; $display("FAIL ident_out: got %h expected %h", out_tr[10], exp_out);
    end
    n_checks++;
    if (out_tr[OBS-1] !== exp_out) begin
      n_fail++; $display("FAIL ident_out_stable: got %h expected %h", out_tr[OBS-1], exp_out);
    end
  endtask

  task automatic test_uniform();
    mat_t a, b, c;
    logic [TENSOR_W-1:0] e18, e23;
    for (int i = 0; i < N; i++) begin
      a[i] = 2; b[i] = 3; c[i] = 5;
      e18[i*DATA_W +: DATA_W] = 16'h0012;
      e23[i*DATA_W +: DATA_W] = 16'h0017;
    end
    run_op(a, b, c, 1'b0, 0);
    n_checks++;
    if (out_tr[10] !== e18) begin n_fail++; $display("FAIL uniform_noacc: got %h expected %h", out_tr[10], e18); end
    run_op(a, b, c, 1'b1, 0);
    n_checks++;
    if (out_tr[10] !== e23) begin n_fail++; $display("FAIL uniform_acc: got %h expected %h", out_tr[10], e23); end
  endtask

  task automatic test_negative();
    mat_t a, b, z;
    logic [TENSOR_W-1:0] exp_out;
    for (int i = 0; i < N; i++) begin
      a[i] = (i % (DIM + 1) == 0) ? -1 : 0;
      b[i] = i + 1;
      z[i] = 0;
      exp_out[i*DATA_W +: DATA_W] = 16'hFFFF - 16'(i);
    end
    run_op(a, b, z, 1'b0, 0);
    n_checks++;
    if (out_tr[10] !== exp_out) begin n_fail++; $display("FAIL negative: got %h expected %h", out_tr[10], exp_out); end
  endtask

  task automatic test_overflow();
    mat_t a, b, z;
    logic [TENSOR_W-1:0] exp_out;
    for (int i = 0; i < N; i++) begin
      a[i] = 16'h4000; b[i] = 2; z[i] = 0;
`ifdef MXU_SAT_EN
      exp_out[i*DATA_W +: DATA_W] = 16'h7FFF;
`else
      exp_out[i*DATA_W +: DATA_W] = 16'h8000;
`endif
    end
    run_op(a, b, z, 1'b0, 0);
    n_checks++;
    if (out_tr[10] !== exp_out) begin n_fail++; $display("FAIL overflow: got %h expected %h", out_tr[10], exp_out); end
  endtask

  task automatic test_random();
    mat_t a, b, c;
    bit acc;
    logic [TENSOR_W-1:0] exp_out;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) begin a[i] = rnd16(); b[i] = rnd16(); c[i] = rnd16(); end
      acc = 1'($urandom_range(0, 1));
      exp_out = ref_mul(a, b, c, acc);
      run_op(a, b, c, acc, 0);
      n_checks++;
      if (out_tr[10] !== exp_out || done_tr[10] !== 1'b1) begin
        n_fail++; $display("FAIL random[%0d]: got %h done=%b expected %h", t, out_tr[10], done_tr[10], exp_out);
      end
    end
  endtask

  task automatic test_ignore_start();
    mat_t a, b, c;
    logic [TENSOR_W-1:0] exp_out;
    int pulses, busy_cycles;
    for (int i = 0; i < N; i++) begin a[i] = rnd16(); b[i] = rnd16(); c[i] = rnd16(); end
    exp_out = ref_mul(a, b, c, 1'b0);
    run_op(a, b, c, 1'b0, 1);
    pulses = 0;
    busy_cycles = 0;
    for (int j = 0; j < OBS; j++) begin
      pulses += int'(done_tr[j]);
      busy_cycles += int'(busy_tr[j]);
    end
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
    n_checks++;
    if (busy_cycles !== 10) begin n_fail++; $display("FAIL ignore_busy: got %0d expected 10", busy_cycles); end
    n_checks++;
    if (out_tr[10] !== exp_out) begin n_fail++; $display("FAIL ignore_out: got %h expected %h", out_tr[10], exp_out); end
  endtask

  task automatic test_operand_change();
    mat_t a, b, c;
    logic [TENSOR_W-1:0] exp_out;
    for (int i = 0; i < N; i++) begin a[i] = rnd16(); b[i] = rnd16(); c[i] = rnd16(); end
    exp_out = ref_mul(a, b, c, 1'b1);
    run_op(a, b, c, 1'b1, 2);
    n_checks++;
    if (out_tr[10] !== exp_out) begin n_fail++; $display("FAIL operand_change: got %h expected %h", out_tr[10], exp_out); end
  endtask

  task automatic test_back_to_back();
    mat_t xa, xb, ya, yb, z;
    logic [TENSOR_W-1:0] ex, ey;
    bit exp_busy, exp_done;
    for (int i = 0; i < N; i++) begin
      xa[i] = rnd16(); xb[i] = rnd16(); ya[i] = rnd16(); yb[i] = rnd16(); z[i] = 0;
    end
    ex = ref_mul(xa, xb, z, 1'b0);
    ey = ref_mul(ya, yb, z, 1'b0);
    a_in = pack(xa); b_in = pack(xb); c_in = '0; accumulate = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    a_in = pack(ya); b_in = pack(yb);
    for (int j = 0; j < 23; j++) begin
      exp_busy = (j <= 9) || (j >= 11 && j <= 20);
      exp_done = (j == 10) || (j == 21);
      n_checks++;
      if (busy !== exp_busy || done !== exp_done) begin
        n_fail++; $display("FAIL b2b_hs[%0d]: got busy=%b done=%b expected %b/%b", j, busy, done, exp_busy, exp_done);
      end
      if (j == 10) begin
        n_checks++;
        if (mxu_out !== ex) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", mxu_out, ex); end
      end
      if (j == 21) begin
        n_checks++;
        if (mxu_out !== ey) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", mxu_out, ey); end
      end
      if (j == 20) start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    mat_t a, b, c;
    logic [TENSOR_W-1:0] exp_out;
    bit found;
    for (int i = 0; i < N; i++) begin a[i] = rnd16(); b[i] = rnd16(); c[i] = rnd16(); end
    a_in = pack(a); b_in = pack(b); c_in = pack(c); accumulate = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = (elem_idx == IDX_W'(5));
    for (int j = 0; j < 20 && !found; j++) begin
      @(posedge clk); #1;
      found = (elem_idx == IDX_W'(5));
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rstmid_reach_idx5: got %0d expected 5", elem_idx); end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || elem_idx !== '0 || mxu_out !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: got busy=%b done=%b idx=%0d out=%h expected all 0", busy, done, elem_idx, mxu_out);
    end
    repeat (2) begin
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_held: got busy=%b done=%b expected 0/0", busy, done);
      end
    end
    #2 reset = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_no_done[%0d]: got busy=%b done=%b expected 0/0", j, busy, done);
      end
    end
    for (int i = 0; i < N; i++) begin a[i] = rnd16(); b[i] = rnd16(); c[i] = rnd16(); end
    exp_out = ref_mul(a, b, c, 1'b1);
    run_op(a, b, c, 1'b1, 0);
    n_checks++;
    if (out_tr[9] !== '0 || done_tr[9] !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_after_early: got out=%h done=%b expected 0/0", out_tr[9], done_tr[9]);
    end
    n_checks++;
    if (done_tr[10] !== 1'b1 || out_tr[10] !== exp_out) begin
      n_fail++; $display("FAIL rstmid_after: got done=%b out=%h expected 1/%h", done_tr[10], out_tr[10], exp_out);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_identity();
    test_uniform();
    test_negative();
    test_overflow();
    test_random();
    test_ignore_start();
    test_operand_change();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
